router_fifo: RTL and testbench

ROUTER_FIFO -- requirements
Module: router_fifo

---
 rtl/router_fifo.sv | 92 +++++++++
 tb/tb_router_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Router output FIFO: DEPTH words of {header_flag, byte}, registered read data,
// and a packet byte counter that is loaded from header words as they are read.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] hdr_q, hdr_d;
  logic [6:0]       pkt_count_q, pkt_count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic          wr_fire, rd_fire;
  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign wr_fire  = write_enb && !full;
  assign rd_fire  = read_enb && !empty;
  assign data_out = data_out_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    hdr_d       = hdr_q;
    pkt_count_d = pkt_count_q;
    data_out_d  = data_out_q;
    if (soft_reset) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      hdr_d       = '0;
      pkt_count_d = '0;
      data_out_d  = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d        = wr_ptr_q + 1'b1;
        hdr_d[wr_idx]   = lfd_state;
      end
      if (rd_fire) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        data_out_d = mem_q[rd_idx];
        // Header byte carries payload length in [7:2]; +1 accounts for parity.
        if (hdr_q[rd_idx]) begin
          pkt_count_d = {1'b0, mem_q[rd_idx][7:2]} + 7'd1;
        end else if (pkt_count_q != '0) begin
          pkt_count_d = pkt_count_q - 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hdr_q       <= '0;
      pkt_count_q <= '0;
      data_out_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      hdr_q       <= hdr_d;
      pkt_count_q <= pkt_count_d;
      data_out_q  <= data_out_d;
    end
  end

  // Byte storage needs no reset: a word is only readable after it is written.
  always_ff @(posedge clock) begin
    if (wr_fire && !soft_reset) begin
      mem_q[wr_idx] <= data_in;
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: a queue-based model predicts data_out,
// pkt_count and flags each cycle; a monitor compares after every clock edge.
module tb_router_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             soft_reset = 1'b0;
  logic             write_enb = 1'b0;
  logic             read_enb = 1'b0;
  logic             lfd_state = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             full, empty;

  router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] dout;
    int         pkt;
    bit         full;
    bit         empty;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] mq[$];
  logic [7:0] m_dout = '0;
  int         m_pkt = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model applies the same cycle and queues the prediction.
  task automatic cycle(input bit we, input bit re, input bit lfd, input bit sr, input logic [7:0] din);
    bit         rd_ok, wr_ok;
    logic [8:0] w;
    exp_t       e;
    @(negedge clock);
    write_enb = we; read_enb = re; lfd_state = lfd; soft_reset = sr; data_in = din;
    if (sr) begin
      mq.delete();
      m_pkt  = 0;
      m_dout = '0;
    end else begin
      rd_ok = re && (mq.size() > 0);
      wr_ok = we && (mq.size() < DEPTH);
      if (rd_ok) begin
        w      = mq.pop_front();
        m_dout = w[7:0];
        if (w[8]) m_pkt = int'(w[7:2]) + 1;
        else if (m_pkt > 0) m_pkt = m_pkt - 1;
      end
      if (wr_ok) mq.push_back({lfd, din});
    end
    e.dout  = m_dout;
    e.pkt   = m_pkt;
    e.full  = (mq.size() == DEPTH);
    e.empty = (mq.size() == 0);
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("data_out", int'(data_out), int'(e.dout));
        check("pkt_count", int'(dut.pkt_count_q), e.pkt);
        check("full", int'(full), int'(e.full));
        check("empty", int'(empty), int'(e.empty));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] b;
    #2;
    check("reset_dout", int'(data_out), 0);
    check("reset_empty", int'(empty), 1);
    check("reset_full", int'(full), 0);
    @(negedge clock);
    reset = 1'b0;

    // Packet: header 0x39 (14 payload), 14 payload bytes, parity.
    cycle(1, 0, 1, 0, 8'h39);
    for (int i = 0; i < 14; i++) cycle(1, 0, 0, 0, 8'($urandom_range(0, 255)));
    cycle(1, 0, 0, 0, 8'h5C);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 8'h00);

    // Read on empty holds data_out.
    cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 1, 0, 0, 8'h00);

    // Fill plus a dropped 17th write of 0xAA.
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, 8'(i * 7 + 1));
    cycle(1, 0, 0, 0, 8'hAA);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 1, 0, 0, 8'h00);

    // 15 stored, then 20 cycles of simultaneous read and write across the wrap.
    for (int i = 0; i < 15; i++) cycle(1, 0, 0, 0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, 8'(8'h60 + i));
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 8'h00);

    // Soft reset with 5 words stored and read/write requested together.
    for (int i = 0; i < 6; i++) cycle(1, 0, (i == 0), 0, 8'(8'hC4 + i));
    cycle(0, 1, 0, 0, 8'h00);
    cycle(1, 1, 0, 1, 8'hEE);
    cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 0, 0, 0, 8'h00);

    // Randomised traffic with occasional headers and soft resets.
    for (int i = 0; i < 400; i++) begin
      b = 8'($urandom_range(0, 255));
      cycle(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0), b);
    end

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 8'(8'h91 + i));
    cycle(1, 1, 0, 0, 8'h95);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("arst_dout", int'(data_out), 0);
    check("arst_empty", int'(empty), 1);
    check("arst_full", int'(full), 0);
    mq.delete();
    m_pkt  = 0;
    m_dout = '0;
    @(negedge clock);
    reset = 1'b0;
    write_enb = 1'b0;
    read_enb = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1, 0, (i == 0), 0, 8'(8'h4B + i));
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 8'h00);

    @(posedge clock);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
